sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
Downstream of the per-sprite image setters (image RAM → palette RAM → 12-bit colour). Merges a background colour and NUM_LAYERS sprite colours into the single 12-bit pixel driven to the VGA DAC. Delays the bounding-box tests to line up with the setters' 2-cycle RAM latency, applies a transparency key and fixed priority, and registers the result.

Parameters:
NUM_LAYERS, 4, number of sprite layers; index 0 has the highest priority
SPRITE_W, 50, sprite width in pixels (all layers)
SPRITE_H, 50, sprite height in pixels (all layers)
SETTER_LATENCY, 2, cycles from x/y presented to setter colour valid (image RAM + palette RAM)
TRANSPARENT_KEY, 12'h0F0, sprite colour treated as see-through

Ports:
clk  input  1  system pixel-pipeline clock, rising edge
reset  input  1  synchronous, active-high
x  input  10  current VGA column (0..639), same value fed to the setters
y  input  9  current VGA row (0..479)
active  input  1  high while x/y lie in the visible area
sprite_x  input  NUM_LAYERS*10  packed sprite origin columns; layer i at [10i+9:10i]
sprite_y  input  NUM_LAYERS*9  packed sprite origin rows
sprite_en  input  NUM_LAYERS  per-layer display enable
sprite_color  input  NUM_LAYERS*12  packed setter outputs, valid SETTER_LATENCY cycles after x/y
bg_color  input  12  background setter output, same latency
pixel_out  output  12  composited colour
pixel_active  output  1  active delayed to match pixel_out
collide  output  1  optional, see Optional Feature

Behaviour:
- Stage 0 (same cycle as x/y): per layer, hit_i = sprite_en[i] & (x >= ox_i) & (x < ox_i+SPRITE_W) & (y >= oy_i) & (y < oy_i+SPRITE_H). Sums are computed one bit wider (11/10 bits) so origins near 639/479 do not wrap; sprites clipped at the right/bottom edge give hit=0 off-screen.
- hit vector and active go through a SETTER_LATENCY-deep shift register, aligned with sprite_color/bg_color.
- Select stage: opaque_i = hit_d[i] & (color_i != TRANSPARENT_KEY). Output the lowest-index opaque layer, else bg_color. If active_d=0, the colour is 12'h000.
- Output register: pixel_out and pixel_active update on every clk. Total latency is SETTER_LATENCY+1 cycles from x/y.
- No stall and no handshake; one pixel per cycle.
- Reset: pixel_out=12'h000, pixel_active=0, collide=0, all delay stages cleared to hit=0/active=0. Output is therefore black for SETTER_LATENCY+1 cycles after reset deasserts.
- Reset mid-frame: pipeline flushes identically; no partial state is retained.
- Origins/enables are sampled at stage 0 only. A change mid-line affects only pixels whose x/y are presented after the change.
- Overlapping opaque layers: the lower index always wins. Exact TRANSPARENT_KEY in a sprite reveals the next layer or the background.

Optional Feature:
Macro: SPRITE_COMPOSITOR_COLLIDE_EN
- Defined:
  - Sticky pending bit sets when opaque_0 & opaque_1 & active_d in the same cycle (e.g. player vs fruit).
  - At the frame-start strobe, collide <= pending and pending clears. The strobe is the delayed x==0 & y==0 & active.
  - If the strobe coincides with a new overlap, that overlap counts toward the new frame.
  - collide therefore holds the previous frame's result for one full frame.
  - Requires NUM_LAYERS >= 2.
- Undefined: no pending logic; collide tied to 0; port retained.

Decomposition:
- Shared package/header (video_pkg): VIDEO_WIDTH=640, VIDEO_HEIGHT=480, BITS_PER_COLOR=12, sprite size 50, TRANSPARENT_KEY, setter latency constant.
- One natural sub-module, sprite_hit_test: single-layer bounding-box comparator, instantiated NUM_LAYERS times in a generate loop.
- The delay line and priority mux stay in the top.

Test Plan:
- Reset held 3 cycles, then x/y sweep with no sprites enabled, bg_color=12'h123 driven with 2-cycle lag → pixel_out=12'h000 for the first 3 cycles, then 12'h123 with pixel_active=1.
- Layer 1 at (100,100), colour 12'hF00; pixel (99,100) vs (100,100) vs (149,149) vs (150,149) → bg, F00, F00, bg. Each appears exactly 3 cycles after its x/y.
- Layers 0 and 1 both at (200,200), colours 12'h00F and 12'hF00 → 12'h00F. Layer 0 colour set to 12'h0F0 → 12'hF00.
- Layer 0 origin (620,470), sweep to (639,479) → hits only within the screen; no wrap hits at x=0..29 or y=0..39.
- Reset asserted mid-line at x=300 → pixel_out=12'h000 and pixel_active=0 on the next edge, with no stale colour after release.
- COLLIDE_EN: overlap layers 0/1 in frame N, separate them in N+1 → collide=1 from N+1 start through N+2 start, then 0. Without the macro, collide stays 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-pipeline constants and types for the sprite compositor.
package video_pkg;
  localparam int VIDEO_WIDTH    = 640;
  localparam int VIDEO_HEIGHT   = 480;
  localparam int BITS_PER_COLOR = 12;
  localparam int X_W            = 10;
  localparam int Y_W            = 9;
  localparam int SPRITE_SIZE    = 50;
  localparam int SETTER_LATENCY = 2;
  localparam logic [BITS_PER_COLOR-1:0] TRANSPARENT_KEY = 12'h0F0;

  typedef logic [BITS_PER_COLOR-1:0] color_t;
endpackage

// File: rtl/sprite_hit_test.sv
// Single-layer bounding-box comparator; purely combinational (stage 0).
module sprite_hit_test
  import video_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_SIZE,
  parameter int SPRITE_H = SPRITE_SIZE
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] ox,
  input  logic [Y_W-1:0] oy,
  input  logic           en,
  output logic           hit
);
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;

  // One extra bit so origins near the right/bottom edge clip instead of wrapping.
  always_comb begin
    x_end = {1'b0, ox} + (X_W+1)'(SPRITE_W);
    y_end = {1'b0, oy} + (Y_W+1)'(SPRITE_H);
    hit   = en & (x >= ox) & ({1'b0, x} < x_end)
               & (y >= oy) & ({1'b0, y} < y_end);
  end
endmodule

// File: rtl/sprite_compositor.sv
// Background + NUM_LAYERS sprite compositor with transparency key and fixed priority.
// Optional frame collision flag (layers 0/1) under SPRITE_COMPOSITOR_COLLIDE_EN.
module sprite_compositor #(
  parameter int                  NUM_LAYERS      = 4,
  parameter int                  SPRITE_W        = video_pkg::SPRITE_SIZE,
  parameter int                  SPRITE_H        = video_pkg::SPRITE_SIZE,
  parameter int                  SETTER_LATENCY  = video_pkg::SETTER_LATENCY,
  parameter video_pkg::color_t   TRANSPARENT_KEY = video_pkg::TRANSPARENT_KEY
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               x,
  input  logic [8:0]               y,
  input  logic                     active,
  input  logic [NUM_LAYERS*10-1:0] sprite_x,
  input  logic [NUM_LAYERS*9-1:0]  sprite_y,
  input  logic [NUM_LAYERS-1:0]    sprite_en,
  input  logic [NUM_LAYERS*12-1:0] sprite_color,
  input  logic [11:0]              bg_color,
  output logic [11:0]              pixel_out,
  output logic                     pixel_active,
  output logic                     collide
);
  import video_pkg::*;

  logic [NUM_LAYERS-1:0] hit;

  genvar g;
  generate
    for (g = 0; g < NUM_LAYERS; g++) begin : g_hit
      sprite_hit_test #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_hit (
        .x  (x),
        .y  (y),
        .ox (sprite_x[g*10 +: 10]),
        .oy (sprite_y[g*9 +: 9]),
        .en (sprite_en[g]),
        .hit(hit[g])
      );
    end
  endgenerate

  // Delay line: stage-0 decisions wait for the setters' RAM latency.
  logic [SETTER_LATENCY-1:0][NUM_LAYERS-1:0] hit_pipe_q, hit_pipe_d;
  logic [SETTER_LATENCY-1:0]                 act_pipe_q, act_pipe_d;

  always_comb begin
    hit_pipe_d    = hit_pipe_q;
    act_pipe_d    = act_pipe_q;
    hit_pipe_d[0] = hit;
    act_pipe_d[0] = active;
    for (int s = 1; s < SETTER_LATENCY; s++) begin
      hit_pipe_d[s] = hit_pipe_q[s-1];
      act_pipe_d[s] = act_pipe_q[s-1];
    end
  end

  logic [NUM_LAYERS-1:0] hit_d;
  logic                  act_d;
  assign hit_d = hit_pipe_q[SETTER_LATENCY-1];
  assign act_d = act_pipe_q[SETTER_LATENCY-1];

  color_t [NUM_LAYERS-1:0] layer_color;
  assign layer_color = sprite_color;

  logic [NUM_LAYERS-1:0] opaque;
  color_t                pixel_q, pixel_d;
  logic                  pixel_active_q, pixel_active_d;

  // Walk from lowest priority up so layer 0 overwrites last.
  always_comb begin
    pixel_d = bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque[i] = hit_d[i] & (layer_color[i] != TRANSPARENT_KEY);
      if (opaque[i]) pixel_d = layer_color[i];
    end
    if (!act_d) pixel_d = '0;
    pixel_active_d = act_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_pipe_q     <= '0;
      act_pipe_q     <= '0;
      pixel_q        <= '0;
      pixel_active_q <= 1'b0;
    end else begin
      hit_pipe_q     <= hit_pipe_d;
      act_pipe_q     <= act_pipe_d;
      pixel_q        <= pixel_d;
      pixel_active_q <= pixel_active_d;
    end
  end

  assign pixel_out    = pixel_q;
  assign pixel_active = pixel_active_q;

`ifdef SPRITE_COMPOSITOR_COLLIDE_EN
  // Needs NUM_LAYERS >= 2: compares layers 0 and 1.
  logic [SETTER_LATENCY-1:0] sof_pipe_q, sof_pipe_d;
  logic                      pending_q, pending_d;
  logic                      collide_q, collide_d;
  logic                      sof_d, overlap;

  always_comb begin
    sof_pipe_d    = sof_pipe_q;
    sof_pipe_d[0] = (x == '0) & (y == '0) & active;
    for (int s = 1; s < SETTER_LATENCY; s++) sof_pipe_d[s] = sof_pipe_q[s-1];
    sof_d   = sof_pipe_q[SETTER_LATENCY-1];
    overlap = opaque[0] & opaque[1] & act_d;
    // An overlap on the strobe cycle belongs to the frame just starting.
    pending_d = (sof_d ? 1'b0 : pending_q) | overlap;
    collide_d = sof_d ? pending_q : collide_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sof_pipe_q <= '0;
      pending_q  <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      sof_pipe_q <= sof_pipe_d;
      pending_q  <= pending_d;
      collide_q  <= collide_d;
    end
  end

  assign collide = collide_q;
`else
  assign collide = 1'b0;
`endif
endmodule
